// File: rtl/bin2bcd_ctrl.sv
// bin2bcd_ctrl: double-dabble binary-to-BCD controller; ports: clk/rst, in_valid/in_ready/in_bin, out_valid/out_ready/out_bcd/out_ovf, busy
module bin2bcd_ctrl #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf,
  output logic                  busy
);
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t r_state, w_next;
  logic [BIN_W-1:0] r_shreg;
  logic [CW-1:0] r_cnt;
  logic [4*DIGITS-1:0] r_dig, w_adj, w_shift;
  logic r_ovf;
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign w_adj[4*k+:4] = (r_dig[4*k+:4] >= 4'd5) ? r_dig[4*k+:4] + 4'd3 : r_dig[4*k+:4];
    if (k == 0) begin : g_lsd
      assign w_shift[3:0] = {w_adj[2:0], r_shreg[BIN_W-1]};
    end else begin : g_hsd
      assign w_shift[4*k+:4] = {w_adj[4*k+:3], w_adj[4*k-1]};
    end
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && in_valid) w_next = SHIFT;
    else if (r_state == SHIFT && r_cnt == CW'(1)) w_next = DONE;
    else if (r_state == DONE && out_ready) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_dig   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && in_valid) begin
        r_shreg <= in_bin;
        r_dig   <= '0;
        r_cnt   <= CW'(BIN_W);
        r_ovf   <= 1'b0;
      end else if (r_state == SHIFT) begin
        r_dig   <= w_shift;
        r_shreg <= r_shreg << 1;
        r_cnt   <= r_cnt - CW'(1);
        r_ovf   <= r_ovf | w_adj[4*DIGITS-1];
      end
    end
  end
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign busy      = r_state == SHIFT;
  assign out_bcd   = r_dig;
  assign out_ovf   = r_ovf;
endmodule

// File: tb/tb_bin2bcd_ctrl.sv
// tb_bin2bcd_ctrl: table-driven and scoreboard checks of bin2bcd_ctrl at 8/3 and 8/2
module tb_bin2bcd_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] in_bin = '0;
  logic in_ready, out_valid, out_ovf, busy;
  logic [11:0] out_bcd;
  logic in_valid2 = 1'b0, out_ready2 = 1'b1;
  logic [7:0] in_bin2 = '0;
  logic in_ready2, out_valid2, out_ovf2, busy2;
  logic [7:0] out_bcd2;
  int n_cmp = 0, n_bad = 0;
  typedef struct {logic [11:0] bcd; logic ovf;} exp_t;
  typedef struct {logic [7:0] bin; logic [11:0] bcd; logic ovf;} vec_t;
  exp_t sb[$];
  vec_t tbl[8];
  int perm[256];
  always #5 clk = ~clk;
  bin2bcd_ctrl #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .out_ovf(out_ovf), .busy(busy));
  bin2bcd_ctrl #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_bin(in_bin2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_bcd(out_bcd2), .out_ovf(out_ovf2), .busy(busy2));
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [11:0] ref_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_underrun", 32'(sb.size()), 1);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("out_bcd", 32'(out_bcd), 32'(e.bcd));
        check("out_ovf", 32'(out_ovf), 32'(e.ovf));
      end
    end
  end
  task automatic run_word(input logic [7:0] b, input logic [11:0] eb, input logic eo);
    int edges, bc;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 1);
    in_bin = b;
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{eb, eo});
    #1 in_valid = 1'b0;
    bc = int'(busy);
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      #1 edges++;
      bc += int'(busy);
    end
    check("latency", edges, 8);
    check("busy_cycles", bc, 8);
    @(negedge clk);
    @(posedge clk);
    #1 check("in_ready_after", 32'(in_ready), 1);
  endtask
  task automatic run2(input logic [7:0] b);
    int n;
    @(negedge clk);
    check("in_ready2", 32'(in_ready2), 1);
    in_bin2 = b;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("out_valid2", 32'(out_valid2), 1);
    check("out_bcd2", 32'(out_bcd2), 32'({4'((int'(b) / 10) % 10), 4'(int'(b) % 10)}));
    check("out_ovf2", 32'(out_ovf2), 32'(b > 8'd99));
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int n, bc;
    tbl[0] = '{8'd255, 12'h255, 1'b0};
    tbl[1] = '{8'd0,   12'h000, 1'b0};
    tbl[2] = '{8'd128, 12'h128, 1'b0};
    tbl[3] = '{8'd173, 12'h173, 1'b0};
    tbl[4] = '{8'd99,  12'h099, 1'b0};
    tbl[5] = '{8'd1,   12'h001, 1'b0};
    tbl[6] = '{8'd10,  12'h010, 1'b0};
    tbl[7] = '{8'd100, 12'h100, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_bcd", 32'(out_bcd), 0);
    check("rst_out_ovf", 32'(out_ovf), 0);
    rst = 1'b0;
    foreach (tbl[i]) run_word(tbl[i].bin, tbl[i].bcd, tbl[i].ovf);
    // back-to-back words with in_valid held high
    @(negedge clk);
    in_bin = 8'd0;
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{12'h000, 1'b0});
    #1 in_bin = 8'd128;
    bc = int'(busy);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
      bc += int'(busy);
    end
    check("b2b_in_ready_done", 32'(in_ready), 0);
    @(posedge clk);
    #1 check("b2b_in_ready_idle", 32'(in_ready), 1);
    sb.push_back('{12'h128, 1'b0});
    @(posedge clk);
    #1 in_valid = 1'b0;
    bc += int'(busy);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
      bc += int'(busy);
    end
    check("b2b_busy_total", bc, 16);
    @(posedge clk);
    #1;
    // backpressure in DONE
    out_ready = 1'b0;
    @(negedge clk);
    in_bin = 8'd77;
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{12'h077, 1'b0});
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    repeat (5) begin
      in_valid = 1'b1;
      in_bin = 8'($urandom);
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_out_bcd", 32'(out_bcd), 32'(ref_bcd(77)));
      check("bp_out_ovf", 32'(out_ovf), 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_in_ready_after", 32'(in_ready), 1);
    check("bp_busy_after", 32'(busy), 0);
    // reset during the 4th shift
    @(negedge clk);
    in_bin = 8'd173;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mid_in_ready", 32'(in_ready), 1);
    check("rst_mid_out_valid", 32'(out_valid), 0);
    check("rst_mid_busy", 32'(busy), 0);
    run_word(8'd173, 12'h173, 1'b0);
    // two-digit instance: overflow then sticky flag cleared
    run2(8'd200);
    run2(8'd99);
    run2(8'd150);
    // full sweep in shuffled order
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < 256; i++) run_word(8'(perm[i]), ref_bcd(perm[i]), 1'b0);
    repeat (2) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
